// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: imem request/response, redirect and decode-side handshake bundle
interface inst_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     Redirect;
  logic [31:0]              RedirectPC;
  logic                     Mem_Req;
  logic [31:0]              Mem_Addr;
  logic                     Mem_Ack;
  logic                     Mem_Valid;
  logic [31:0]              Mem_Data;
  logic                     Out_Valid;
  logic                     Out_Ready;
  logic [31:0]              Out_PC;
  logic [31:0]              Out_PC4;
  logic [31:0]              Out_Inst;
  logic [$clog2(DEPTH):0]   Count;
  modport master (
    input  Redirect, RedirectPC, Mem_Ack, Mem_Valid, Mem_Data, Out_Ready,
    output Mem_Req, Mem_Addr, Out_Valid, Out_PC, Out_PC4, Out_Inst, Count
  );
  modport slave (
    output Redirect, RedirectPC, Mem_Ack, Mem_Valid, Mem_Data, Out_Ready,
    input  Mem_Req, Mem_Addr, Out_Valid, Out_PC, Out_PC4, Out_Inst, Count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: owns fetch PC, keeps one imem request in flight, queues {PC, PC+4, inst} for decode
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                Clk,
  input logic                Reset,
  inst_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
  state_t        r_state, w_next;
  logic [31:0]   r_fpc, r_ipc;
  logic [95:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_issue, w_push, w_pop;
  assign bus.Mem_Req   = (r_state == S_REQ) && (r_count < FULL) && !Reset;
  assign bus.Mem_Addr  = r_fpc;
  assign bus.Out_Valid = r_count != '0;
  assign bus.Out_PC    = r_mem[r_rptr][95:64];
  assign bus.Out_PC4   = r_mem[r_rptr][63:32];
  assign bus.Out_Inst  = r_mem[r_rptr][31:0];
  assign bus.Count     = r_count;
  // A response in REQ is a protocol error and is ignored; in DROP it only releases the stale slot.
  always_comb begin
    w_issue = bus.Mem_Req && bus.Mem_Ack;
    w_push  = (r_state == S_WAIT) && bus.Mem_Valid && !bus.Redirect;
    w_pop   = bus.Out_Valid && bus.Out_Ready && !bus.Redirect;
    w_next  = r_state == S_REQ ? (w_issue ? (bus.Redirect ? S_DROP : S_WAIT) : S_REQ)
            : bus.Mem_Valid    ? S_REQ
            : bus.Redirect     ? S_DROP : r_state;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_REQ;
      r_fpc   <= RESET_PC;
      r_ipc   <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_fpc   <= bus.Redirect ? (bus.RedirectPC & ~32'd3) : w_issue ? r_fpc + 32'd4 : r_fpc;
      if (w_issue) r_ipc <= r_fpc;
      r_wptr  <= bus.Redirect ? '0 : r_wptr + AW'(w_push);
      r_rptr  <= bus.Redirect ? '0 : r_rptr + AW'(w_pop);
      r_count <= bus.Redirect ? '0 : r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset && w_push) r_mem[r_wptr] <= {r_ipc, r_ipc + 32'd4, bus.Mem_Data};
  end
  // Issue is gated on free space, so a push can never find the queue full.
  a_no_overflow: assert property (@(posedge Clk) disable iff (Reset) w_push |-> r_count < FULL);
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed checks of fetch order, backpressure, redirects, PC wrap and reset
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  inst_fetch_queue_if #(.DEPTH(4)) bus ();
  inst_fetch_queue_if #(.DEPTH(4)) b2 ();
  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (.Clk(clk), .Reset(rst), .bus(b2));
  int n_chk = 0;
  int n_pass = 0;
  function automatic logic [31:0] f_inst(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Main DUT stimulus and a variable-latency memory model (latency counted from acceptance)
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic        ready = 1'b0;
  logic        ack_en = 1'b1;
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data = 32'd0;
  assign bus.Redirect   = redir;
  assign bus.RedirectPC = rpc;
  assign bus.Out_Ready  = ready;
  assign bus.Mem_Ack    = ack_en & bus.Mem_Req;
  assign bus.Mem_Valid  = m_valid;
  assign bus.Mem_Data   = m_data;
  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        m_valid <= 1'b1;
        m_data  <= f_inst(paddr);
        pend    <= 1'b0;
      end else cnt <= cnt - 1;
    end
    if (bus.Mem_Req && bus.Mem_Ack) begin
      if (lat == 1) begin
        m_valid <= 1'b1;
        m_data  <= f_inst(bus.Mem_Addr);
      end else begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= bus.Mem_Addr;
      end
    end
  end
  // Second DUT: free-running single-cycle memory, always ready, records its first three outputs
  logic        m2_valid = 1'b0;
  logic [31:0] m2_data = 32'd0;
  logic [31:0] c_pc [3];
  logic [31:0] c_pc4 [3];
  logic [31:0] c_inst [3];
  int          n2 = 0;
  assign b2.Redirect   = 1'b0;
  assign b2.RedirectPC = 32'd0;
  assign b2.Out_Ready  = 1'b1;
  assign b2.Mem_Ack    = b2.Mem_Req;
  assign b2.Mem_Valid  = m2_valid;
  assign b2.Mem_Data   = m2_data;
  always @(posedge clk) begin
    m2_valid <= b2.Mem_Req;
    m2_data  <= f_inst(b2.Mem_Addr);
  end
  always @(negedge clk) begin
    if (!rst && b2.Out_Valid && n2 < 3) begin
      c_pc[n2]   <= b2.Out_PC;
      c_pc4[n2]  <= b2.Out_PC4;
      c_inst[n2] <= b2.Out_Inst;
      n2         <= n2 + 1;
    end
  end
  task automatic pop_expect(input logic [31:0] pc);
    int k = 0;
    while (!bus.Out_Valid && k < 30) begin
      tick();
      k++;
    end
    check("pop_valid", 32'(bus.Out_Valid), 32'd1);
    check("pop_pc", bus.Out_PC, pc);
    check("pop_pc4", bus.Out_PC4, pc + 32'd4);
    check("pop_inst", bus.Out_Inst, f_inst(pc));
    tick();
  endtask
  task automatic wait_req(input logic [31:0] a);
    int k = 0;
    while (!(bus.Mem_Req && bus.Mem_Addr == a) && k < 40) begin
      tick();
      k++;
    end
    check("wait_req_valid", 32'(bus.Mem_Req), 32'd1);
    check("wait_req_addr", bus.Mem_Addr, a);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.Count), 32'd0);
    check("rst_valid", 32'(bus.Out_Valid), 32'd0);
    check("rst_req", 32'(bus.Mem_Req), 32'd0);
    check("rst_addr", bus.Mem_Addr, 32'h0);
    check("rst_addr2", b2.Mem_Addr, 32'hFFFF_FFF8);
    rst = 1'b0;
    ready = 1'b1;
    #1;
    check("req_after_rst", 32'(bus.Mem_Req), 32'd1);
    for (int i = 0; i < 4; i++) pop_expect(32'(i * 4));
    // backpressure fills the queue and stops issue
    rst = 1'b1;
    ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("full_count", 32'(bus.Count), 32'd4);
    check("full_no_req", 32'(bus.Mem_Req), 32'd0);
    check("full_head", bus.Out_PC, 32'h0);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) pop_expect(32'(i * 4));
    // redirect while waiting for 0x8, stale response lands three cycles after acceptance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b0;
    lat = 1;
    wait_req(32'h8);
    lat = 3;
    tick();
    check("wait_count", 32'(bus.Count), 32'd2);
    check("wait_no_req", 32'(bus.Mem_Req), 32'd0);
    redir = 1'b1;
    rpc = 32'h43;
    tick();
    redir = 1'b0;
    check("redir_count", 32'(bus.Count), 32'd0);
    check("redir_valid", 32'(bus.Out_Valid), 32'd0);
    check("drop_no_req", 32'(bus.Mem_Req), 32'd0);
    tick();
    check("drop_no_req2", 32'(bus.Mem_Req), 32'd0);
    tick();
    check("drop_done_req", 32'(bus.Mem_Req), 32'd1);
    check("drop_done_addr", bus.Mem_Addr, 32'h40);
    check("drop_no_push", 32'(bus.Count), 32'd0);
    lat = 1;
    ready = 1'b1;
    pop_expect(32'h40);
    // redirect coinciding with the response goes straight back to REQ
    wait_req(32'h48);
    check("head_44", bus.Out_PC, 32'h44);
    tick();
    redir = 1'b1;
    rpc = 32'h100;
    tick();
    redir = 1'b0;
    check("fast_req", 32'(bus.Mem_Req), 32'd1);
    check("fast_addr", bus.Mem_Addr, 32'h100);
    check("fast_count", 32'(bus.Count), 32'd0);
    // reset with two entries queued and a response still outstanding
    ready = 1'b0;
    wait_req(32'h108);
    lat = 4;
    tick();
    check("pre_rst_count", 32'(bus.Count), 32'd2);
    check("pre_rst_valid", 32'(bus.Out_Valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_count", 32'(bus.Count), 32'd0);
    check("mid_rst_valid", 32'(bus.Out_Valid), 32'd0);
    check("mid_rst_req", 32'(bus.Mem_Req), 32'd0);
    rst = 1'b0;
    ack_en = 1'b0;
    repeat (3) tick();
    check("late_rsp_count", 32'(bus.Count), 32'd0);
    check("late_rsp_valid", 32'(bus.Out_Valid), 32'd0);
    check("late_rsp_req", 32'(bus.Mem_Req), 32'd1);
    check("late_rsp_addr", bus.Mem_Addr, 32'h0);
    ack_en = 1'b1;
    lat = 1;
    ready = 1'b1;
    pop_expect(32'h0);
    pop_expect(32'h4);
    // PC wrap on the second instance
    check("wrap_n", 32'(n2), 32'd3);
    check("wrap_pc0", c_pc[0], 32'hFFFF_FFF8);
    check("wrap_pc1", c_pc[1], 32'hFFFF_FFFC);
    check("wrap_pc2", c_pc[2], 32'h0000_0000);
    check("wrap_pc4_1", c_pc4[1], 32'h0000_0000);
    check("wrap_inst2", c_inst[2], f_inst(32'h0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
